// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed common-anode 7-segment scan driver with frame-boundary commit
// Optional: define LEADING_ZERO_BLANK_EN to darken leading zero digits.
module seg_scan_driver #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int NUM_DIGITS = 4,
    parameter int GHOST_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(NUM_DIGITS);
    localparam int DW  = 4 * NUM_DIGITS;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  pending_q, pending_d;
    logic                  shown_q, shown_d;
    logic [DW-1:0]         stg_dig_q, stg_dig_d, shd_dig_q, shd_dig_d;
    logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0] stg_blank_q, stg_blank_d, shd_blank_q, shd_blank_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fs_q, fs_d;
    logic                  terminal, last_slot, wrap;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [3:0]            cur_digit;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;
`endif

    // Digit i>0 goes dark when it and every digit to its left are zero.
    always_comb begin
        lz_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run && (shd_dig_q[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run;
        end
`endif
    end

    always_comb begin
        terminal  = (presc_q == PW'(DIV - 1));
        last_slot = (idx_q == IW'(NUM_DIGITS - 1));
        wrap      = terminal && last_slot;

        presc_d = terminal ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (terminal) begin
            idx_d = last_slot ? '0 : idx_q + 1'b1;
        end

        stg_dig_d   = stg_dig_q;
        stg_dp_d    = stg_dp_q;
        stg_blank_d = stg_blank_q;
        shd_dig_d   = shd_dig_q;
        shd_dp_d    = shd_dp_q;
        shd_blank_d = shd_blank_q;
        pending_d   = pending_q;
        shown_d     = shown_q;

        if (load) begin
            stg_dig_d   = digits;
            stg_dp_d    = dp_in;
            stg_blank_d = blank_in;
            pending_d   = 1'b1;
        end
        // A load coinciding with the wrap bypasses staging so it lands in the new frame.
        if (wrap && (pending_q || load)) begin
            shd_dig_d   = load ? digits   : stg_dig_q;
            shd_dp_d    = load ? dp_in    : stg_dp_q;
            shd_blank_d = load ? blank_in : stg_blank_q;
            pending_d   = 1'b0;
            shown_d     = 1'b1;
        end

        cur_digit = shd_dig_q[4*int'(idx_q) +: 4];
        an_d      = '1;
        seg_d     = 7'h7F;
        dp_d      = 1'b1;
        if (shown_q && (presc_q >= PW'(GHOST_CYC))) begin
            an_d[idx_q] = 1'b0;
            if (!(shd_blank_q[idx_q] || lz_blank[idx_q])) begin
                seg_d = decode(cur_digit);
            end
            dp_d = ~shd_dp_q[idx_q];
        end
        fs_d = wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            shown_q     <= 1'b0;
            stg_dig_q   <= '0;
            stg_dp_q    <= '0;
            stg_blank_q <= '1;
            shd_dig_q   <= '0;
            shd_dp_q    <= '0;
            shd_blank_q <= '1;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            an_q        <= '1;
            fs_q        <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            shown_q     <= shown_d;
            stg_dig_q   <= stg_dig_d;
            stg_dp_q    <= stg_dp_d;
            stg_blank_q <= stg_blank_d;
            shd_dig_q   <= shd_dig_d;
            shd_dp_q    <= shd_dp_d;
            shd_blank_q <= shd_blank_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            fs_q        <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver against a cycle-count reference model
module tb_seg_scan_driver;
    localparam int CLK_HZ = 1000;
    localparam int SCAN_HZ = 100;
    localparam int N = 4;
    localparam int GHOST = 2;
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int FRAME = DIV * N;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [15:0]  digits = '0;
    logic [3:0]   dp_in = '0;
    logic [3:0]   blank_in = '0;
    logic         load = 1'b0;
    logic [6:0]   seg;
    logic         dp;
    logic [3:0]   an;
    logic         frame_start;

    int tests = 0;
    int fails = 0;

    seg_scan_driver #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .NUM_DIGITS(N), .GHOST_CYC(GHOST)
    ) dut (
        .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: time is the edge count since reset release.
    int          t;
    logic [15:0] st_dig, sh_dig;
    logic [3:0]  st_dp, sh_dp, st_bl, sh_bl;
    bit          pend, shown;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        st_dig = '0; sh_dig = '0;
        st_dp = '0; sh_dp = '0;
        st_bl = '1; sh_bl = '1;
        pend = 1'b0; shown = 1'b0;
    endtask

    function automatic bit lz(input int i);
`ifdef LEADING_ZERO_BLANK_EN
        if (i == 0) return 1'b0;
        for (int j = i; j < N; j++) if (sh_dig[4*j +: 4] != 4'h0) return 1'b0;
        return 1'b1;
`else
        return (i < 0);
`endif
    endfunction

    task automatic step(input bit ld);
        int presc, idx;
        bit wrap;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        load = ld;
        presc = t % DIV;
        idx = (t / DIV) % N;
        wrap = (t % FRAME) == FRAME - 1;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        if (shown && presc >= GHOST) begin
            e_an[idx] = 1'b0;
            e_seg = (sh_bl[idx] || lz(idx)) ? 7'h7F : dec[sh_dig[4*idx +: 4]];
            e_dp = ~sh_dp[idx];
        end
        @(posedge clk);
        if (wrap && (pend || ld)) begin
            sh_dig = ld ? digits : st_dig;
            sh_dp = ld ? dp_in : st_dp;
            sh_bl = ld ? blank_in : st_bl;
            pend = 1'b0;
            shown = 1'b1;
        end else if (ld) begin
            pend = 1'b1;
        end
        if (ld) begin
            st_dig = digits; st_dp = dp_in; st_bl = blank_in;
        end
        t++;
        @(negedge clk);
        load = 1'b0;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("frame_start", 32'(frame_start), 32'(wrap));
    endtask

    logic [3:0] tan [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] tseg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic       tdp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_fs", 32'(frame_start), 32'h0);
        rst = 1'b1;

        // Dark display, frame_start every frame
        for (int i = 0; i < 200; i++) step(1'b0);

        digits = 16'h1234; blank_in = 4'h0; dp_in = 4'b0100;
        step(1'b1);
        n = 0;
        while ((t % FRAME) != 0 && n < 2 * FRAME) begin step(1'b0); n++; end
        for (int j = 1; j <= FRAME; j++) begin
            int slot, off;
            step(1'b0);
            slot = (j - 1) / DIV;
            off = (j - 1) % DIV;
            chk("tbl_an", 32'(an), (off < GHOST) ? 32'hF : 32'(tan[slot]));
            chk("tbl_seg", 32'(seg), (off < GHOST) ? 32'h7F : 32'(tseg[slot]));
            chk("tbl_dp", 32'(dp), (off < GHOST) ? 32'h1 : 32'(tdp[slot]));
        end

        // Mid-frame reload must not tear the current frame
        for (int i = 0; i < 15; i++) step(1'b0);
        digits = 16'hABCD; dp_in = 4'b0001;
        step(1'b1);
        for (int i = 0; i < 90; i++) begin
            digits = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom);
            step(1'b0);
        end

        // Load exactly in the frame-wrap cycle
        while ((t % FRAME) != FRAME - 1) step(1'b0);
        digits = 16'h9E0F; dp_in = 4'b1000; blank_in = 4'b0010;
        step(1'b1);
        for (int i = 0; i < 50; i++) step(1'b0);

        // Randomised loads with inputs wiggling between loads
        for (int i = 0; i < 1500; i++) begin
            digits = 16'($urandom);
            dp_in = 4'($urandom);
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step($urandom_range(0, 29) == 0);
        end
        digits = 16'h7654; dp_in = 4'h0; blank_in = 4'h0;
        step(1'b1);
        for (int i = 0; i < 2 * FRAME; i++) step(1'b0);

        // Asynchronous reset while digit 2 is lit
        n = 0;
        while (an !== 4'hB && n < 400) begin step(1'b0); n++; end
        chk("reach_anB", 32'(an), 32'hB);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp", 32'(dp), 32'h1);
        chk("arst_fs", 32'(frame_start), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) step(1'b0);
        digits = 16'h0C08; dp_in = 4'b0010; blank_in = 4'h0;
        step(1'b1);
        for (int i = 0; i < 3 * FRAME; i++) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
